// File: rtl/irq_prio_ctrl_if.sv
// rtl/irq_prio_ctrl_if.sv - request/handshake/select bundle of the interrupt priority controller
// `intr` is the CPU interrupt request line (the name `int` is a reserved word).
interface irq_prio_ctrl_if #(parameter int CW = 2);
  localparam int N = 1 << CW;

  logic [N-1:0]  irq;
  logic [N-1:0]  mask;
  logic          ack;
  logic          eoi;
  logic          intr;
  logic [CW-1:0] s;
  logic          busy;
  logic [N-1:0]  pend;

  modport master (
    output irq, mask, ack, eoi,
    input  intr, s, busy, pend
  );

  modport slave (
    input  irq, mask, ack, eoi,
    output intr, s, busy, pend
  );
endinterface

// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - edge-captured interrupt controller with fixed priority and ack/eoi handshake
// Drives the select of the downstream handler-vector mux; one episode at a time, no preemption.
module irq_prio_ctrl #(
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            rst,
  irq_prio_ctrl_if.slave  bus
);
  localparam int N = 1 << CW;

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] s_q, s_d, sel;
  logic [N-1:0]  irq_q, pending_q, pending_d;
  logic [N-1:0]  eligible, clr;

  assign eligible = pending_q & ~bus.mask;

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[k]) sel = CW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          s_d     = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.ack) begin
          clr[s_q] = 1'b1;
          state_d  = SERV;
        end
      end
      SERV: begin
        if (bus.eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh rise on the acknowledged line wins over the clear.
  assign pending_d = (pending_q & ~clr) | (bus.irq & ~irq_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      irq_q     <= bus.irq;
      pending_q <= pending_d;
    end
  end

  assign bus.intr = (state_q == REQ);
  assign bus.busy = (state_q == SERV);
  assign bus.s    = s_q;
  assign bus.pend = pending_q;
endmodule
